// File: rtl/alu_mp_sequencer.sv
// Multi-precision arithmetic sequencer: runs NBYTES-wide add/sub/shl1/shr1 one byte
// per cycle through the core's external combinational 8-bit ALU, chaining carry itself.
module alu_mp_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [1:0]            op_sel_i,
  input  logic [8*NBYTES-1:0]   a_i,
  input  logic [8*NBYTES-1:0]   b_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [8*NBYTES-1:0]   result_o,
  output logic                  carry_o,
  output logic                  neg_o,
  output logic                  zero_o,
  output logic [7:0]            alu_rs_o,
  output logic [7:0]            alu_rt_o,
  output logic [8:0]            alu_op_o,
  input  logic [7:0]            alu_result_i,
  input  logic                  alu_carry_i
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  // Core ALU mnemonics (upper 8 bits of the 9-bit opcode)
  localparam logic [7:0] ALU_ADD = 8'h01;
  localparam logic [7:0] ALU_NEG = 8'h02;
  localparam logic [7:0] ALU_LSL = 8'h03;
  localparam logic [7:0] ALU_LSR = 8'h04;
  localparam logic [7:0] ALU_OR  = 8'h05;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_SHL = 2'b10;
  localparam logic [1:0] SEL_SHR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_OP,
    S_FIX,
    S_DONE
  } state_t;

  typedef logic [NBYTES-1:0][7:0] bytes_t;

  state_t        state, next_state;
  logic [1:0]    op_q;
  bytes_t        a_q, b_q, r_q, r_next;
  logic [KW-1:0] k_q, k_next;
  logic          cin_q, cin_next;
  logic          cout_q, cout_next;
  logic [7:0]    tmp_q, tmp_next;
  logic [7:0]    alu_mnem;
  logic          accept;
  logic          last_byte;
  logic          advance;
  logic          load_result;

  assign accept    = (state == S_IDLE) && start_i;
  assign last_byte = (op_q == SEL_SHR) ? (k_q == '0) : (k_q == KW'(NBYTES - 1));
  assign busy_o    = (state != S_IDLE);
  assign done_o    = (state == S_DONE);
  assign alu_op_o  = {alu_mnem, 1'b0};

  // Next-state and ALU drive; the carry-in of each byte is folded in by a separate FIX
  // cycle that adds 1 (add/sub) or ORs the carried bit into the vacated end (shifts).
  always_comb begin
    next_state  = state;
    alu_mnem    = 8'h00;
    alu_rs_o    = 8'h00;
    alu_rt_o    = 8'h00;
    r_next      = r_q;
    k_next      = k_q;
    cin_next    = cin_q;
    cout_next   = cout_q;
    tmp_next    = tmp_q;
    advance     = 1'b0;
    load_result = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start_i) begin
          next_state = (op_sel_i == SEL_SUB) ? S_PREP : S_OP;
          k_next     = (op_sel_i == SEL_SHR) ? KW'(NBYTES - 1) : '0;
          cin_next   = (op_sel_i == SEL_SUB);
        end
      end
      S_PREP: begin
        alu_mnem   = ALU_NEG;
        alu_rt_o   = b_q[k_q];
        tmp_next   = ~b_q[k_q];
        next_state = S_OP;
      end
      S_OP: begin
        alu_rs_o = a_q[k_q];
        unique case (op_q)
          SEL_ADD: begin
            alu_mnem  = ALU_ADD;
            alu_rt_o  = b_q[k_q];
            cout_next = alu_carry_i;
          end
          SEL_SUB: begin
            alu_mnem  = ALU_ADD;
            alu_rt_o  = tmp_q;
            cout_next = alu_carry_i;
          end
          SEL_SHL: begin
            alu_mnem  = ALU_LSL;
            alu_rt_o  = 8'h01;
            cout_next = a_q[k_q][7];
          end
          default: begin
            alu_mnem  = ALU_LSR;
            alu_rt_o  = 8'h01;
            cout_next = a_q[k_q][0];
          end
        endcase
        r_next[k_q] = alu_result_i;
        if (cin_q) next_state = S_FIX;
        else       advance    = 1'b1;
      end
      S_FIX: begin
        alu_rs_o = r_q[k_q];
        unique case (op_q)
          SEL_SHL: begin
            alu_mnem = ALU_OR;
            alu_rt_o = 8'h01;
          end
          SEL_SHR: begin
            alu_mnem = ALU_OR;
            alu_rt_o = 8'h80;
          end
          default: begin
            alu_mnem  = ALU_ADD;
            alu_rt_o  = 8'h01;
            cout_next = cout_q | alu_carry_i;
          end
        endcase
        r_next[k_q] = alu_result_i;
        advance     = 1'b1;
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    if (advance) begin
      cin_next = cout_next;
      if (last_byte) begin
        next_state  = S_DONE;
        load_result = 1'b1;
      end else begin
        k_next     = (op_q == SEL_SHR) ? (k_q - KW'(1)) : (k_q + KW'(1));
        next_state = (op_q == SEL_SUB) ? S_PREP : S_OP;
      end
    end
  end

  // State and datapath registers; the visible result and flags only change when the
  // final byte completes, so they are valid in the done cycle and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      k_q      <= '0;
      cin_q    <= 1'b0;
      cout_q   <= 1'b0;
      tmp_q    <= 8'h00;
      result_o <= '0;
      carry_o  <= 1'b0;
      neg_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      state  <= next_state;
      r_q    <= r_next;
      k_q    <= k_next;
      cin_q  <= cin_next;
      cout_q <= cout_next;
      tmp_q  <= tmp_next;
      if (accept) begin
        op_q <= op_sel_i;
        a_q  <= a_i;
        b_q  <= b_i;
      end
      if (load_result) begin
        result_o <= r_next;
        carry_o  <= cout_next;
        neg_o    <= r_next[NBYTES-1][7];
        zero_o   <= (r_next == '0);
      end
    end
  end

endmodule
